// File: rtl/seg7_scroll_ctrl.sv
// Nibble-scrolling controller for an 8-digit seven-segment display word.
// Define SEG7_SCROLL_WRAP_EN to rotate continuously; by default one pass zero-fills and stops.
module seg7_scroll_ctrl #(
  parameter int unsigned CLK_DIV = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] din,
  input  logic        en,
  input  logic        dir,
  output logic [31:0] disp,
  output logic        step_pulse,
  output logic        cycle_pulse,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } state_e;

  localparam logic [31:0] PrescMax = 32'(CLK_DIV - 1);

  state_e      state;
  logic [31:0] presc;
  logic [2:0]  step_cnt;
  logic        armed;

  logic        presc_hit;
  logic        last_step;
  logic [3:0]  fill;
  logic [31:0] shifted;

  assign load_ready = 1'b1;
  assign state_o    = state;

  assign presc_hit = (presc == PrescMax);
  assign last_step = (step_cnt == 3'd7);

`ifdef SEG7_SCROLL_WRAP_EN
  // Rotate: the nibble leaving one end re-enters at the other.
  assign fill = dir ? disp[31:28] : disp[3:0];
`else
  assign fill = 4'h0;
`endif

  assign shifted = dir ? {disp[27:0], fill} : {fill, disp[31:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      disp        <= 32'h0;
      presc       <= 32'h0;
      step_cnt    <= 3'd0;
      armed       <= 1'b0;
      step_pulse  <= 1'b0;
      cycle_pulse <= 1'b0;
    end else begin
      step_pulse  <= 1'b0;
      cycle_pulse <= 1'b0;

      // A load overrides everything else this cycle, including a coincident tick.
      if (load_valid) begin
        disp     <= din;
        presc    <= 32'h0;
        step_cnt <= 3'd0;
        armed    <= 1'b1;
      end

      case (state)
        StIdle: begin
          if (!load_valid && en && armed) begin
            state <= StRun;
          end
        end

        StRun: begin
          if (!load_valid) begin
            if (!en) begin
              state <= StHold;
            end else if (presc_hit) begin
              presc       <= 32'h0;
              disp        <= shifted;
              step_cnt    <= step_cnt + 3'd1;
              step_pulse  <= 1'b1;
              cycle_pulse <= last_step;
`ifndef SEG7_SCROLL_WRAP_EN
              if (last_step) begin
                state <= StIdle;
                armed <= 1'b0;
              end
`endif
            end else begin
              presc <= presc + 32'h1;
            end
          end
        end

        StHold: begin
          if (!load_valid && en) begin
            state <= StRun;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_cycle_with_step : assert property (@(posedge clk) disable iff (rst)
    cycle_pulse |-> step_pulse);
  a_legal_state : assert property (@(posedge clk) disable iff (rst)
    state_o != 2'b11);
`endif

endmodule
